conv_stream_feeder: RTL

Streams an activation map from on-chip buffer memory into a convolver in row-major raster order, one element per enabled beat. Sits between the activation buffer and the convolver. It produces the convolver's clear, enable and data inputs and consumes its end-of-convolution flag. A downstream stall input pauses the stream without losing elements, so the output writer can throttle the convolution.

---
 rtl/conv_stream_feeder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/conv_stream_feeder.sv
// Raster-order activation streamer: buffer reads -> 2-entry skid FIFO -> convolver beats.
// Optional border padding is enabled by defining CONV_STREAM_FEEDER_PAD_EN.
module conv_stream_feeder #(
  parameter int unsigned N             = 16,
  parameter int unsigned AddrW         = 16,
  parameter int unsigned MaxMatrixSize = 64,
  parameter int unsigned FlushBeats    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [13:0]             matrix_size_i,
  input  logic [AddrW-1:0]        base_addr_i,
`ifdef CONV_STREAM_FEEDER_PAD_EN
  input  logic [1:0]              pad_i,
`endif
  output logic                    busy_o,
  output logic                    done_o,
  output logic [13:0]             eff_size_o,
  output logic                    rd_en_o,
  output logic [AddrW-1:0]        rd_addr_o,
  input  logic [N-1:0]            rd_data_i,
  input  logic                    stall_i,
  output logic                    conv_rst_o,
  output logic                    conv_en_o,
  output logic signed [N-1:0]     conv_data_o,
  input  logic                    conv_end_i
);

  // Counter width covers the largest side plus the widest border on both sides.
  localparam int unsigned SideW     = $clog2(MaxMatrixSize + 7);
  localparam logic [15:0] FlushLast = 16'(FlushBeats - 1);

  typedef enum logic [2:0] {StIdle, StClear, StStream, StFlush, StWaitEnd} state_e;

  state_e             state_q, state_d;
  logic [13:0]        eff_q, eff_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [SideW-1:0]   row_q, row_d, col_q, col_d;
  logic               last_q, last_d;
  logic               inflight_q, inflight_d;
  logic               infl_pad_q, infl_pad_d;
  logic [N-1:0]       fifo_q [2];
  logic [N-1:0]       fifo_d [2];
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [15:0]        flush_q, flush_d;
  logic               done_q, done_d;

  logic [13:0]        eff_start;
  logic [SideW-1:0]   side_m1;
  logic               pad_cell;
  logic [N-1:0]       arrive_data, head;
  logic               fifo_valid, pop, push, pop_store, issue;
  logic [2:0]         occ_after;

`ifdef CONV_STREAM_FEEDER_PAD_EN
  logic [1:0]         pad_q, pad_d;
  logic [SideW-1:0]   lo_w, hi_w;

  assign pad_d     = (state_q == StIdle && start_i) ? pad_i : pad_q;
  assign eff_start = matrix_size_i + {11'd0, pad_i, 1'b0};
  assign lo_w      = SideW'(pad_q);
  assign hi_w      = SideW'(eff_q) - lo_w;
  assign pad_cell  = (row_q < lo_w) || (row_q >= hi_w) || (col_q < lo_w) || (col_q >= hi_w);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pad_q <= '0;
    else       pad_q <= pad_d;
  end
`else
  assign eff_start = matrix_size_i;
  assign pad_cell  = 1'b0;
`endif

  assign side_m1 = SideW'(eff_q - 14'd1);

  // Data read last cycle arrives now; padded slots travel the same path as a zero.
  assign arrive_data = infl_pad_q ? '0 : rd_data_i;
  assign fifo_valid  = (cnt_q != 2'd0) || inflight_q;
  assign head        = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : arrive_data;
  assign pop         = fifo_valid && !stall_i;
  assign push        = inflight_q && !(pop && cnt_q == 2'd0);
  assign pop_store   = pop && (cnt_q != 2'd0);
  assign occ_after   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue       = (state_q == StStream) && !last_q && (occ_after < 3'd2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start_i && matrix_size_i != 14'd0) state_d = StClear;
      StClear:   state_d = StStream;
      StStream: begin
        if (last_q && occ_after == 3'd0) state_d = (FlushBeats == 0) ? StWaitEnd : StFlush;
      end
      StFlush:   if (!stall_i && flush_q == FlushLast) state_d = StWaitEnd;
      StWaitEnd: if (conv_end_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    eff_d      = eff_q;
    addr_d     = addr_q;
    row_d      = row_q;
    col_d      = col_q;
    last_d     = last_q;
    flush_d    = flush_q;
    done_d     = 1'b0;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = issue;
    infl_pad_d = issue && pad_cell;

    if (state_q == StIdle && start_i) begin
      eff_d   = eff_start;
      addr_d  = base_addr_i;
      row_d   = '0;
      col_d   = '0;
      last_d  = 1'b0;
      flush_d = '0;
      done_d  = (matrix_size_i == 14'd0);
    end

    if (state_q == StWaitEnd && conv_end_i) done_d = 1'b1;

    // Interior elements are contiguous in memory, so a running address replaces r*size+c.
    if (issue) begin
      if (!pad_cell) addr_d = addr_q + AddrW'(1);
      if (col_q == side_m1) begin
        col_d = '0;
        row_d = row_q + SideW'(1);
        if (row_q == side_m1) last_d = 1'b1;
      end else begin
        col_d = col_q + SideW'(1);
      end
    end

    if (push) begin
      fifo_d[wr_ptr_q] = arrive_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop_store) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop_store};

    if (state_q == StFlush && !stall_i) flush_d = flush_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      eff_q      <= '0;
      addr_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      last_q     <= 1'b0;
      inflight_q <= 1'b0;
      infl_pad_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      flush_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      eff_q      <= eff_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      last_q     <= last_d;
      inflight_q <= inflight_d;
      infl_pad_q <= infl_pad_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    busy_o      = (state_q != StIdle);
    done_o      = done_q;
    eff_size_o  = eff_q;
    conv_rst_o  = (state_q == StClear);
    rd_en_o     = issue && !pad_cell;
    rd_addr_o   = rd_en_o ? addr_q : '0;
    conv_en_o   = (fifo_valid || state_q == StFlush) && !stall_i;
    conv_data_o = fifo_valid ? $signed(head) : '0;
  end

endmodule
